paddle_update_ctrl: RTL and testbench

Controller between the mouse position buffers and the game logic. It arbitrates position-update requests from two requesters: player A on the local mouse, player B on the secondary source. Each granted value is clamped to the legal paddle range and held in a pending register. Pending values are committed to frame-stable outputs only at the start of vertical blanking, so paddles never move mid-frame. It also turns the left mouse button into one serve pulse per frame.

---
 rtl/paddle_update_ctrl_if.sv | 29 ++
 rtl/paddle_update_ctrl.sv | 163 ++++++++++++++++
 tb/tb_paddle_update_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_update_ctrl_if.sv
// Paddle update bus: requester handshakes, frame strobe, mouse button and committed outputs.
interface paddle_update_ctrl_if;
  localparam int unsigned YW = 12;

  logic          vblank_start;
  logic          req_a;
  logic [YW-1:0] ypos_a;
  logic          ack_a;
  logic          req_b;
  logic [YW-1:0] ypos_b;
  logic          ack_b;
  logic          mouse_left_in;
  logic [YW-1:0] ypos_out;
  logic [YW-1:0] ypos_out_sec;
  logic          serve;
  logic          update_done;

  // Environment side: requesters, video timing and mouse.
  modport master (
    output vblank_start, req_a, ypos_a, req_b, ypos_b, mouse_left_in,
    input  ack_a, ack_b, ypos_out, ypos_out_sec, serve, update_done
  );

  // Controller side.
  modport slave (
    input  vblank_start, req_a, ypos_a, req_b, ypos_b, mouse_left_in,
    output ack_a, ack_b, ypos_out, ypos_out_sec, serve, update_done
  );
endinterface

// File: rtl/paddle_update_ctrl.sv
// Paddle update controller: round-robin grants of two position requesters,
// clamped pending values committed at vertical blanking, one serve per frame.
module paddle_update_ctrl #(
  parameter int unsigned V_RES    = 768,
  parameter int unsigned PADDLE_H = 100,
  parameter int unsigned Y_RESET  = 334
) (
  input  logic                 clk,
  input  logic                 rst,
  paddle_update_ctrl_if.slave  io_bus
);

  localparam int unsigned   YW     = 12;
  localparam logic [YW-1:0] Y_MAX  = YW'(V_RES - PADDLE_H);
  localparam logic [YW-1:0] Y_INIT = YW'(Y_RESET);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_rr_ptr;      // 0: A wins a tie, 1: B wins a tie
  logic          r_commit_pend;
  logic          r_valid_a;
  logic          r_valid_b;
  logic [YW-1:0] r_pend_a;
  logic [YW-1:0] r_pend_b;

  logic          r_ack_a;
  logic          r_ack_b;
  logic          r_update_done;
  logic [YW-1:0] r_ypos_out;
  logic [YW-1:0] r_ypos_out_sec;

  logic          r_mouse_q;
  logic          r_mouse_qq;
  logic          r_serve;
  logic          r_serve_lock;

  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_commit;
  logic          w_rise;
  logic          w_serve_fire;

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  assign w_grant_a    = (r_state == S_GRANT_A);
  assign w_grant_b    = (r_state == S_GRANT_B);
  assign w_commit     = (r_state == S_COMMIT);
  assign w_rise       = r_mouse_q & ~r_mouse_qq;
  // The lock is released by the commit exiting this cycle, so a coincident edge still serves.
  assign w_serve_fire = w_rise & (~r_serve_lock | w_commit);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: commit has priority, ties go to the round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_commit_pend || io_bus.vblank_start)   w_state_nxt = S_COMMIT;
        else if (io_bus.req_a && io_bus.req_b)      w_state_nxt = r_rr_ptr ? S_GRANT_B : S_GRANT_A;
        else if (io_bus.req_a)                      w_state_nxt = S_GRANT_A;
        else if (io_bus.req_b)                      w_state_nxt = S_GRANT_B;
        else                                        w_state_nxt = S_IDLE;
      end
      S_GRANT_A: w_state_nxt = S_IDLE;
      S_GRANT_B: w_state_nxt = S_IDLE;
      S_COMMIT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Pending values, valid flags, arbitration pointer and deferred-commit flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_a      <= Y_INIT;
      r_pend_b      <= Y_INIT;
      r_valid_a     <= 1'b0;
      r_valid_b     <= 1'b0;
      r_rr_ptr      <= 1'b0;
      r_commit_pend <= 1'b0;
    end else begin
      if (w_grant_a) begin
        r_pend_a  <= clamp_y(io_bus.ypos_a);
        r_valid_a <= 1'b1;
        r_rr_ptr  <= 1'b1;
      end else if (w_commit) begin
        r_valid_a <= 1'b0;
      end
      if (w_grant_b) begin
        r_pend_b  <= clamp_y(io_bus.ypos_b);
        r_valid_b <= 1'b1;
        r_rr_ptr  <= 1'b0;
      end else if (w_commit) begin
        r_valid_b <= 1'b0;
      end
      // A blanking strobe that cannot be served now is remembered, never counted twice.
      if (io_bus.vblank_start && (r_state != S_IDLE)) r_commit_pend <= 1'b1;
      else if (w_commit)                              r_commit_pend <= 1'b0;
    end
  end

  // Acknowledges, frame-stable positions and commit strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_a        <= 1'b0;
      r_ack_b        <= 1'b0;
      r_update_done  <= 1'b0;
      r_ypos_out     <= Y_INIT;
      r_ypos_out_sec <= Y_INIT;
    end else begin
      r_ack_a       <= (w_state_nxt == S_GRANT_A);
      r_ack_b       <= (w_state_nxt == S_GRANT_B);
      r_update_done <= w_commit;
      if (w_commit && r_valid_a) r_ypos_out     <= r_pend_a;
      if (w_commit && r_valid_b) r_ypos_out_sec <= r_pend_b;
    end
  end

  // Mouse button edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mouse_q  <= 1'b0;
      r_mouse_qq <= 1'b0;
    end else begin
      r_mouse_q  <= io_bus.mouse_left_in;
      r_mouse_qq <= r_mouse_q;
    end
  end

  // One serve pulse per frame, re-armed by each commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_serve      <= 1'b0;
      r_serve_lock <= 1'b0;
    end else begin
      r_serve <= w_serve_fire;
      if (w_serve_fire)  r_serve_lock <= 1'b1;
      else if (w_commit) r_serve_lock <= 1'b0;
    end
  end

  assign io_bus.ack_a        = r_ack_a;
  assign io_bus.ack_b        = r_ack_b;
  assign io_bus.update_done  = r_update_done;
  assign io_bus.ypos_out     = r_ypos_out;
  assign io_bus.ypos_out_sec = r_ypos_out_sec;
  assign io_bus.serve        = r_serve;

endmodule

// File: tb/tb_paddle_update_ctrl.sv
// Scoreboard bench for paddle_update_ctrl: directed corner cases plus random traffic.
module tb_paddle_update_ctrl;

  localparam int Y_MAX_M = 768 - 100;
  localparam int Y_RST_M = 334;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  paddle_update_ctrl_if io();

  paddle_update_ctrl #(.V_RES(768), .PADDLE_H(100), .Y_RESET(334)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .io_bus (io)
  );

  typedef struct { int side; int cyc; } ack_t;
  typedef struct { int a; int b; int cyc; } commit_t;

  ack_t    q_ack[$];
  commit_t q_commit[$];
  int      q_serve[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: last granted value per side, committed outputs, serve lock.
  int m_out_a, m_out_b, m_pend_a, m_pend_b;
  bit m_val_a, m_val_b, m_lock;
  int m_tie_side;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event at cycle %0d was not expected", name, cyc);
  endtask

  function automatic int mclamp(input int v);
    return (v > Y_MAX_M) ? Y_MAX_M : v;
  endfunction

  task automatic model_reset();
    m_out_a = Y_RST_M; m_out_b = Y_RST_M;
    m_pend_a = Y_RST_M; m_pend_b = Y_RST_M;
    m_val_a = 0; m_val_b = 0; m_lock = 0;
    m_tie_side = 0;
  endtask

  task automatic model_grant(input int side, input int val);
    if (side == 0) begin m_pend_a = mclamp(val); m_val_a = 1; end
    else           begin m_pend_b = mclamp(val); m_val_b = 1; end
    m_tie_side = 1 - side;
  endtask

  task automatic model_commit(input int exp_cyc);
    commit_t e;
    if (m_val_a) m_out_a = m_pend_a;
    if (m_val_b) m_out_b = m_pend_b;
    m_val_a = 0; m_val_b = 0; m_lock = 0;
    e.a = m_out_a; e.b = m_out_b; e.cyc = exp_cyc;
    q_commit.push_back(e);
  endtask

  task automatic push_ack(input int side, input int exp_cyc);
    ack_t e;
    e.side = side; e.cyc = exp_cyc;
    q_ack.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  task automatic mon_ack(input int side);
    ack_t e;
    if (q_ack.size() == 0) fail_evt(side == 0 ? "ack_a_unexpected" : "ack_b_unexpected");
    else begin
      e = q_ack.pop_front();
      chk("ack_side", side, e.side);
      chk("ack_cycle", cyc, e.cyc);
    end
  endtask

  task automatic mon_commit();
    commit_t e;
    if (q_commit.size() == 0) fail_evt("update_done_unexpected");
    else begin
      e = q_commit.pop_front();
      chk("commit_ypos_out", int'(io.ypos_out), e.a);
      chk("commit_ypos_out_sec", int'(io.ypos_out_sec), e.b);
      chk("commit_cycle", cyc, e.cyc);
    end
  endtask

  task automatic mon_serve();
    int e;
    if (q_serve.size() == 0) fail_evt("serve_unexpected");
    else begin
      e = q_serve.pop_front();
      chk("serve_cycle", cyc, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (io.ack_a === 1'b1)       mon_ack(0);
      if (io.ack_b === 1'b1)       mon_ack(1);
      if (io.update_done === 1'b1) mon_commit();
      if (io.serve === 1'b1)       mon_serve();
    end
  end

  // Stimulus tasks start and end just after a falling edge.
  task automatic do_req(input int side, input int val);
    bit got;
    got = 0;
    push_ack(side, cyc + 1);
    if (side == 0) begin io.req_a = 1'b1; io.ypos_a = 12'(val); end
    else           begin io.req_b = 1'b1; io.ypos_b = 12'(val); end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if ((side == 0 && io.ack_a === 1'b1) || (side == 1 && io.ack_b === 1'b1)) got = 1;
    end
    if (!got) fail_evt("ack_timeout");
    if (side == 0) io.req_a = 1'b0; else io.req_b = 1'b0;
    model_grant(side, val);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_vblank();
    model_commit(cyc + 2);
    io.vblank_start = 1'b1;
    @(negedge clk);
    io.vblank_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_press();
    if (!m_lock) begin
      q_serve.push_back(cyc + 2);
      m_lock = 1;
    end
    io.mouse_left_in = 1'b1;
    repeat (2) @(negedge clk);
    io.mouse_left_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int va[3];
    int vb[3];
    int ga, gb, seen, first, op, val, g;
    bit upd_a, upd_b, got;

    va = '{50, 100, 150};
    vb = '{700, 300, 250};
    rst_n = 1'b0;
    io.vblank_start = 1'b0; io.req_a = 1'b0; io.req_b = 1'b0;
    io.ypos_a = '0; io.ypos_b = '0; io.mouse_left_in = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ypos_out", int'(io.ypos_out), Y_RST_M);
    chk("rst_ypos_out_sec", int'(io.ypos_out_sec), Y_RST_M);
    chk("rst_ack_a", int'(io.ack_a), 0);
    chk("rst_ack_b", int'(io.ack_b), 0);
    chk("rst_serve", int'(io.serve), 0);
    chk("rst_update_done", int'(io.update_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ypos_out", int'(io.ypos_out), Y_RST_M);
    chk("post_rst_ypos_out_sec", int'(io.ypos_out_sec), Y_RST_M);

    // Basic grants and commits, including clamp boundaries
    do_req(0, 200);  do_vblank();
    do_req(1, 900);  do_vblank();
    do_req(1, 668);  do_vblank();
    do_req(0, 0);    do_vblank();
    do_req(1, 669);  do_req(0, 667); do_vblank();
    do_vblank();

    // Blanking and request at the same idle edge: commit first, grant follows
    model_commit(cyc + 2);
    push_ack(0, cyc + 3);
    io.vblank_start = 1'b1; io.req_a = 1'b1; io.ypos_a = 12'(500);
    @(negedge clk);
    io.vblank_start = 1'b0;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (io.ack_a === 1'b1) got = 1;
    end
    if (!got) fail_evt("ack_timeout_same_edge");
    io.req_a = 1'b0;
    model_grant(0, 500);
    repeat (2) @(negedge clk);
    do_vblank();

    // Both sides requesting continuously: strict alternation, last value wins
    first = m_tie_side;
    for (int i = 0; i < 6; i++) push_ack(first ^ (i & 1), cyc + 1 + 2 * i);
    ga = 0; gb = 0; seen = 0; upd_a = 0; upd_b = 0;
    io.ypos_a = 12'(va[0]); io.ypos_b = 12'(vb[0]);
    io.req_a = 1'b1; io.req_b = 1'b1;
    for (int t = 0; t < 60 && seen < 6; t++) begin
      @(negedge clk);
      if (upd_a) begin io.ypos_a = 12'(va[ga]); upd_a = 0; end
      if (upd_b) begin io.ypos_b = 12'(vb[gb]); upd_b = 0; end
      if (io.ack_a === 1'b1) begin
        model_grant(0, va[(ga < 3) ? ga : 2]); ga++; seen++; upd_a = (ga < 3);
      end
      if (io.ack_b === 1'b1) begin
        model_grant(1, vb[(gb < 3) ? gb : 2]); gb++; seen++; upd_b = (gb < 3);
      end
      if (seen >= 6) begin io.req_a = 1'b0; io.req_b = 1'b0; end
    end
    if (seen < 6) fail_evt("pair_timeout");
    io.req_a = 1'b0; io.req_b = 1'b0;
    repeat (2) @(negedge clk);
    do_vblank();

    // Blanking during GRANT_B, plus a second strobe while the commit is pending
    push_ack(1, cyc + 1);
    io.req_b = 1'b1; io.ypos_b = 12'(400);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (io.ack_b === 1'b1) got = 1;
    end
    if (!got) fail_evt("ack_timeout_vblank_grant");
    g = cyc;
    model_grant(1, 400);
    model_commit(g + 3);
    io.vblank_start = 1'b1;
    io.req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    io.vblank_start = 1'b0;
    repeat (4) @(negedge clk);

    // Serve: three presses in a frame give one pulse; re-armed after commit
    do_press(); do_press(); do_press();
    do_vblank();
    do_press();
    do_vblank();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          case ($urandom_range(0, 5))
            0:       val = 0;
            1:       val = Y_MAX_M + int'($urandom_range(0, 2)) - 1;
            2:       val = 4095;
            default: val = int'($urandom_range(0, 4095));
          endcase
          do_req(op, val);
        end
        2:       do_vblank();
        default: do_press();
      endcase
    end
    do_vblank();

    // Asynchronous reset in the middle of GRANT_A
    push_ack(0, cyc + 1);
    io.req_a = 1'b1; io.ypos_a = 12'(123);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (io.ack_a === 1'b1) got = 1;
    end
    if (!got) fail_evt("ack_timeout_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack_a", int'(io.ack_a), 0);
    chk("async_rst_ypos_out", int'(io.ypos_out), Y_RST_M);
    chk("async_rst_ypos_out_sec", int'(io.ypos_out_sec), Y_RST_M);
    io.req_a = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset the tie pointer favours A again
    push_ack(0, cyc + 1);
    push_ack(1, cyc + 3);
    io.ypos_a = 12'(10); io.ypos_b = 12'(20);
    io.req_a = 1'b1; io.req_b = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && seen < 2; t++) begin
      @(negedge clk);
      if (io.ack_a === 1'b1) begin io.req_a = 1'b0; model_grant(0, 10); seen++; end
      if (io.ack_b === 1'b1) begin io.req_b = 1'b0; model_grant(1, 20); seen++; end
    end
    if (seen < 2) fail_evt("ack_timeout_post_reset");
    io.req_a = 1'b0; io.req_b = 1'b0;
    repeat (2) @(negedge clk);
    do_vblank();

    repeat (5) @(negedge clk);
    chk("ack_events_left", q_ack.size(), 0);
    chk("commit_events_left", q_commit.size(), 0);
    chk("serve_events_left", q_serve.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
